mult_accum: RTL

Downstream consumer of the mult block's product output. Accumulates a stream of products into one sum per group, which makes it the accumulate half of a MAC/dot-product datapath. Input uses a valid/ready handshake. A group ends after NUM_TERMS products or on an early in_last. The registered sum is presented on a valid/ready output and held until the consumer takes it.

---
 rtl/mult_accum_if.sv | 27 ++
 rtl/mult_accum.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mult_accum_if.sv
// Handshake bundle for mult_accum: product input channel and result output channel.
// master = upstream producer plus result consumer; slave = the accumulator.
interface mult_accum_if #(
  parameter int PRODUCT_WIDTH = 16,
  parameter int OUT_WIDTH     = 18,
  parameter int COUNT_WIDTH   = 3
);
  logic                     in_valid;
  logic                     in_ready;
  logic [PRODUCT_WIDTH-1:0] product;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_WIDTH-1:0]     result;
  logic                     out_overflow;
  logic [COUNT_WIDTH-1:0]   out_count;

  modport master (
    output in_valid, product, in_last, out_ready,
    input  in_ready, out_valid, result, out_overflow, out_count
  );

  modport slave (
    input  in_valid, product, in_last, out_ready,
    output in_ready, out_valid, result, out_overflow, out_count
  );
endinterface

// File: rtl/mult_accum.sv
// Accumulates a stream of products into one sum per group (accumulate half of a MAC).
// Define MULT_ACCUM_SAT_EN to saturate each add instead of wrapping modulo 2^OUT_WIDTH.
module mult_accum #(
  parameter int PRODUCT_WIDTH = 16,
  parameter bit IS_SIGNED     = 1'b0,
  parameter int NUM_TERMS     = 4,
  parameter int OUT_WIDTH     = 18,
  localparam int COUNT_WIDTH  = $clog2(NUM_TERMS + 1)
) (
  input logic         clk,
  input logic         rst_n,
  mult_accum_if.slave bus
);
  localparam int SUM_WIDTH = OUT_WIDTH + 1;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                 state_reg;
  logic [OUT_WIDTH-1:0]   acc_reg;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic                   ovf_reg;
  logic [OUT_WIDTH-1:0]   result_reg;
  logic [COUNT_WIDTH-1:0] out_count_reg;
  logic                   out_ovf_reg;
  logic                   out_valid_reg;
  logic                   in_ready_reg;

  logic                   product_sign;
  logic [SUM_WIDTH-1:0]   product_ext;
  logic [SUM_WIDTH-1:0]   acc_ext;
  logic [SUM_WIDTH-1:0]   sum_raw;
  logic                   step_ovf;
  logic [OUT_WIDTH-1:0]   sum_next;
  logic [COUNT_WIDTH-1:0] count_next;
  logic                   accept;
  logic                   group_end;

  // Both operands are widened by one bit so the true sum is always representable.
  assign product_sign = IS_SIGNED & bus.product[PRODUCT_WIDTH-1];

  for (genvar gi = 0; gi < SUM_WIDTH; gi++) begin : g_ext
    if (gi < PRODUCT_WIDTH) begin : g_data
      assign product_ext[gi] = bus.product[gi];
    end else begin : g_sign
      assign product_ext[gi] = product_sign;
    end
  end

  assign acc_ext = {IS_SIGNED & acc_reg[OUT_WIDTH-1], acc_reg};
  assign sum_raw = acc_ext + product_ext;

  // Signed: the two top bits disagree when the sum left the OUT_WIDTH range.
  assign step_ovf = IS_SIGNED ? (sum_raw[OUT_WIDTH] ^ sum_raw[OUT_WIDTH-1])
                              : sum_raw[OUT_WIDTH];

`ifdef MULT_ACCUM_SAT_EN
  logic [OUT_WIDTH-1:0] sat_max;
  logic [OUT_WIDTH-1:0] sat_min;

  assign sat_max = IS_SIGNED ? {1'b0, {(OUT_WIDTH-1){1'b1}}} : {OUT_WIDTH{1'b1}};
  assign sat_min = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  always_comb begin
    sum_next = sum_raw[OUT_WIDTH-1:0];
    if (step_ovf) begin
      // The top bit of the widened sum gives the direction of a signed overflow.
      if (IS_SIGNED && sum_raw[OUT_WIDTH]) begin
        sum_next = sat_min;
      end else begin
        sum_next = sat_max;
      end
    end
  end
`else
  assign sum_next = sum_raw[OUT_WIDTH-1:0];
`endif

  assign count_next = count_reg + COUNT_WIDTH'(1);
  assign accept     = bus.in_valid && in_ready_reg;
  assign group_end  = bus.in_last || (count_next == COUNT_WIDTH'(NUM_TERMS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ACCUM;
      acc_reg       <= '0;
      count_reg     <= '0;
      ovf_reg       <= 1'b0;
      result_reg    <= '0;
      out_count_reg <= '0;
      out_ovf_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (accept) begin
            acc_reg   <= sum_next;
            count_reg <= count_next;
            ovf_reg   <= ovf_reg | step_ovf;
            if (group_end) begin
              result_reg    <= sum_next;
              out_count_reg <= count_next;
              out_ovf_reg   <= ovf_reg | step_ovf;
              out_valid_reg <= 1'b1;
              in_ready_reg  <= 1'b0;
              state_reg     <= HOLD;
            end
          end
        end
        HOLD: begin
          // Result stays frozen until taken; the accept bubble follows the handshake.
          if (bus.out_ready) begin
            acc_reg       <= '0;
            count_reg     <= '0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= ACCUM;
          end
        end
        default: begin
          state_reg <= ACCUM;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_reg;
  assign bus.out_valid    = out_valid_reg;
  assign bus.result       = result_reg;
  assign bus.out_count    = out_count_reg;
  assign bus.out_overflow = out_ovf_reg;
endmodule
